// File: rtl/uart_tx_pkt_sched.sv
// Packet scheduler in front of a UART transmitter.
// It frames the 16-bit button state as a 5-byte packet:
//   header, sequence, buttons[7:0], buttons[15:8], XOR checksum.
// A packet is sent when the buttons change or when the heartbeat expires.
// Bytes are handed to the transmitter one at a time.
// A per-byte timeout abandons the packet if the transmitter stalls.
module uart_tx_pkt_sched #(
    parameter int unsigned c_HEARTBEAT_CYCLES = 32'd2500000,
    parameter int unsigned c_TIMEOUT_CYCLES   = 32'd4096,
    parameter logic [7:0]  c_HEADER           = 8'hA5
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_ENABLE,
    input  logic [15:0] i_BUTTONS,
    input  logic        i_TX_ACTIVE,
    input  logic        i_TX_DONE,
    output logic        o_TX_DV,
    output logic [7:0]  o_TX_BYTE,
    output logic        o_BUSY,
    output logic        o_PKT_DONE,
    output logic        o_ERR,
    output logic [7:0]  o_SEQ
);

    localparam logic [31:0] HB_MAX   = 32'(c_HEARTBEAT_CYCLES - 32'd1);
    localparam logic [31:0] TO_MAX   = 32'(c_TIMEOUT_CYCLES - 32'd1);
    localparam logic [2:0]  LAST_IDX = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] last_r;
    logic [15:0] snap_r;
    logic [7:0]  seq_r;
    logic [31:0] hb_cnt_r;
    logic [31:0] to_cnt_r;
    logic [2:0]  idx_r;
    logic        tx_dv_r;
    logic [7:0]  tx_byte_r;
    logic        busy_r;
    logic        pkt_done_r;
    logic        err_r;

    logic        trigger_s;
    logic [7:0]  cur_byte_s;

    // Checksum: XOR of the four leading packet bytes.
    function automatic logic [7:0] xor_chk(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        return b0 ^ b1 ^ b2 ^ b3;
    endfunction

    // Selects packet byte idx from the frozen snapshot and the sequence number.
    function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [7:0] seq,
                                            input logic [15:0] snap);
        logic [7:0] b;
        case (idx)
            3'd0:    b = c_HEADER;
            3'd1:    b = seq;
            3'd2:    b = snap[7:0];
            3'd3:    b = snap[15:8];
            3'd4:    b = xor_chk(c_HEADER, seq, snap[7:0], snap[15:8]);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Start condition: a button change or heartbeat expiry.
    // Both arriving together still yield a single packet.
    always_comb begin
        trigger_s  = 1'b0;
        cur_byte_s = pkt_byte(idx_r, seq_r, snap_r);
        if (i_ENABLE && ((i_BUTTONS != last_r) || (hb_cnt_r == HB_MAX))) begin
            trigger_s = 1'b1;
        end else begin
            trigger_s = 1'b0;
        end
    end

    // Packet sequencer.
    // State, counters and every output are registered here.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_r    <= ST_IDLE;
            last_r     <= 16'h0000;
            snap_r     <= 16'h0000;
            seq_r      <= 8'h00;
            hb_cnt_r   <= 32'd0;
            to_cnt_r   <= 32'd0;
            idx_r      <= 3'd0;
            tx_dv_r    <= 1'b0;
            tx_byte_r  <= 8'h00;
            busy_r     <= 1'b0;
            pkt_done_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            tx_dv_r    <= 1'b0;
            pkt_done_r <= 1'b0;
            err_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (trigger_s) begin
                        snap_r   <= i_BUTTONS;
                        idx_r    <= 3'd0;
                        busy_r   <= 1'b1;
                        hb_cnt_r <= 32'd0;
                        state_r  <= ST_ISSUE;
                    end else if (!i_ENABLE) begin
                        hb_cnt_r <= 32'd0;
                    end else if (hb_cnt_r != HB_MAX) begin
                        hb_cnt_r <= hb_cnt_r + 32'd1;
                    end else begin
                        hb_cnt_r <= hb_cnt_r;
                    end
                end
                ST_ISSUE: begin
                    // Only offer a byte once the transmitter is free.
                    // This gives exactly one request per byte.
                    if (!i_TX_ACTIVE) begin
                        tx_dv_r   <= 1'b1;
                        tx_byte_r <= cur_byte_s;
                        to_cnt_r  <= 32'd0;
                        state_r   <= ST_WAIT;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    // tx_byte_r is left untouched.
                    // The transmitter samples it for the whole frame.
                    if (i_TX_DONE) begin
                        if (idx_r < LAST_IDX) begin
                            idx_r   <= idx_r + 3'd1;
                            state_r <= ST_ISSUE;
                        end else begin
                            state_r <= ST_FINISH;
                        end
                    end else if (to_cnt_r == TO_MAX) begin
                        // Abort without touching seq/last.
                        // The same content goes out again on the next trigger.
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 32'd1;
                    end
                end
                ST_FINISH: begin
                    pkt_done_r <= 1'b1;
                    last_r     <= snap_r;
                    seq_r      <= seq_r + 8'd1;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_TX_DV    = tx_dv_r;
    assign o_TX_BYTE  = tx_byte_r;
    assign o_BUSY     = busy_r;
    assign o_PKT_DONE = pkt_done_r;
    assign o_ERR      = err_r;
    assign o_SEQ      = seq_r;

endmodule

// File: doc/uart_tx_pkt_sched.md
Name: uart_tx_pkt_sched

Overview:
- Packet scheduler that sits in front of the UART transmitter and sequences the controller button state into a framed 5-byte packet.
- Decides when to send: on a button change, or on heartbeat timer expiry.
- Drives the transmitter's data-valid/parallel-byte handshake one byte at a time and waits for each byte's done pulse.
- Recovers from a stalled transmitter via a per-byte timeout.

Parameters:
- c_HEARTBEAT_CYCLES, 2500000: idle cycles before an unconditional resend; 100 ms at 25 MHz.
- c_TIMEOUT_CYCLES, 4096: max cycles to wait for i_TX_DONE per byte before abort; must exceed 10 × cycles-per-bit + 2.
- c_HEADER, 8'hA5: packet sync byte.

Ports:
- i_CLK  in  1  system clock
- i_RESET  in  1  asynchronous, active-high reset
- i_ENABLE  in  1  permits new packets to start
- i_BUTTONS  in  16  button state, already synchronised/debounced upstream
- i_TX_ACTIVE  in  1  transmitter busy flag
- i_TX_DONE  in  1  transmitter one-cycle byte-complete pulse
- o_TX_DV  out  1  one-cycle request to transmitter
- o_TX_BYTE  out  8  byte to transmit
- o_BUSY  out  1  high from packet start until return to IDLE
- o_PKT_DONE  out  1  one-cycle pulse when a packet completes
- o_ERR  out  1  one-cycle pulse on timeout abort
- o_SEQ  out  8  sequence number of the next packet

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - All outputs are registered.
  - Reset clears all outputs, r_LAST (last sent buttons), r_SEQ, the heartbeat counter, the timeout counter and the byte index, and puts the FSM in IDLE.
- Packet format, bytes 0..4:
  - c_HEADER, r_SEQ, r_SNAP[7:0], r_SNAP[15:8], CHK.
  - CHK = XOR of bytes 0..3.
- Heartbeat counter:
  - Increments each cycle in IDLE while i_ENABLE=1.
  - Held at 0 while i_ENABLE=0.
  - Cleared when a packet starts.
  - Saturates at c_HEARTBEAT_CYCLES-1.
- Trigger (IDLE only): i_ENABLE=1 AND (i_BUTTONS != r_LAST OR heartbeat counter == c_HEARTBEAT_CYCLES-1).
  - A simultaneous change and heartbeat yields one packet.
- FSM states:
  - IDLE:
    - On trigger: latch r_SNAP=i_BUTTONS, idx=0, o_BUSY=1, go ISSUE.
  - ISSUE:
    - If i_TX_ACTIVE=0: o_TX_DV=1 for exactly this one cycle, o_TX_BYTE=byte[idx], clear timeout counter, go WAIT.
    - Otherwise hold in ISSUE with o_TX_DV=0.
    - First o_TX_DV occurs 2 cycles after the trigger cycle when the transmitter is idle.
  - WAIT:
    - o_TX_BYTE held stable; the transmitter samples parallel data throughout the frame.
    - On i_TX_DONE=1: if idx<4, idx++ and go ISSUE; else go FINISH.
    - If the timeout counter reaches c_TIMEOUT_CYCLES-1 first: pulse o_ERR and go IDLE.
    - On abort, r_SEQ and r_LAST are unchanged, so the same content is retransmitted on the next trigger.
  - FINISH:
    - Pulse o_PKT_DONE, r_LAST=r_SNAP, r_SEQ=r_SEQ+1 (mod 256, wraps 255→0), o_BUSY=0, go IDLE.
- Handshake rules:
  - i_TX_DONE outside WAIT is ignored.
  - o_TX_DV is never asserted twice for one byte.
- Mid-operation conditions:
  - i_BUTTONS changing mid-packet does not alter bytes in flight; after FINISH the change is detected in IDLE and a new packet starts.
  - i_ENABLE deasserted mid-packet: the current packet completes; no new start.
  - Reset mid-packet: immediate return to IDLE with o_TX_DV=0. The partially sent packet is not completed or resumed.
- o_SEQ reflects r_SEQ continuously.

Test Plan:
- Reset, i_ENABLE=1, i_BUTTONS=16'h0000, c_HEARTBEAT_CYCLES=1000, transmitter model acknowledges each byte after 50 cycles:
  - No packet until cycle 1000.
  - Heartbeat packet bytes A5,00,00,00,A5.
  - o_PKT_DONE pulse; o_SEQ becomes 1.
- i_BUTTONS=16'h1234 while idle:
  - o_TX_DV 2 cycles later.
  - Bytes A5,01,34,12,82.
  - o_SEQ becomes 2.
  - Heartbeat counter restarts.
- i_BUTTONS changes to 16'hFFFF during byte 2 of a packet for 16'h0001:
  - Current packet carries 01,00.
  - A second packet with FF,FF follows immediately after o_PKT_DONE.
- Transmitter model withholds i_TX_DONE on byte 1, c_TIMEOUT_CYCLES=200:
  - o_ERR pulses 200 cycles after o_TX_DV.
  - o_SEQ unchanged.
  - Next packet resends the identical sequence number and payload.
- i_TX_ACTIVE held high at ISSUE for 30 cycles:
  - o_TX_DV stays 0 throughout, then asserts exactly once on the cycle after i_TX_ACTIVE falls.
  - Stray i_TX_DONE pulses in IDLE are ignored.
- Run 256 packets: o_SEQ wraps 255→0. Then assert i_RESET mid-WAIT: all outputs go 0 asynchronously and the FSM is in IDLE.
